// File: rtl/operand_reader_pkg.sv
// Shared constants for the operand reader: FSM state encoding and default widths.
package operand_reader_pkg;

    localparam int DATA_W_DEF    = 16;
    localparam int ADDR_W_DEF    = 3;
    localparam int STALL_MAX_DEF = 15;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RD_A  = 3'd1;
    localparam logic [2:0] CAP_A = 3'd2;
    localparam logic [2:0] RD_B  = 3'd3;
    localparam logic [2:0] CAP_B = 3'd4;
    localparam logic [2:0] FIN   = 3'd5;

endpackage

// File: rtl/operand_reader_stall_counter.sv
// Saturating count of consecutive not-valid samples for the operand being fetched.
// Latency: count updates on the clock edge. Backpressure: none, driven by the reader FSM.
module stall_counter #(
    parameter int STALL_MAX = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic at_max
);

    localparam int                CNT_W = $clog2(STALL_MAX + 1);
    localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STALL_MAX);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && cnt != LIMIT) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // High when one more not-valid sample brings the count to the limit.
    assign at_max = (cnt >= LIMIT - CNT_W'(1));

endmodule

// File: rtl/operand_reader.sv
// Fetches one or two operands over a single bank read port, re-reading until valid; optional BYPASS_EN.
// Latency: done 3 cycles after start (one operand) or 5 (two), +2 per not-valid sample.
// Backpressure: start is ignored while busy; stalls on rd_valid=0 up to STALL_MAX samples, then err.
module operand_reader
    import operand_reader_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int STALL_MAX = STALL_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              two_op,
    input  logic [ADDR_W-1:0] src_a,
    input  logic [ADDR_W-1:0] src_b,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_valid,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b
);

    logic [2:0]        state;
    logic [ADDR_W-1:0] src_b_q;
    logic              two_op_q;
    logic              cap;
    logic              bypass;
    logic              opnd_ok;
    logic [DATA_W-1:0] opnd;
    logic              at_max;

    assign cap = (state == CAP_A) || (state == CAP_B);

`ifdef BYPASS_EN
    // rd_addr still holds the address being captured while in a CAP state.
    assign bypass = cap && wb_en && (wb_addr == rd_addr);
`else
    logic unused_wb;
    assign unused_wb = ^{wb_en, wb_addr, wb_data};
    assign bypass    = 1'b0;
`endif

    assign opnd_ok = rd_valid || bypass;
    assign opnd    = bypass ? wb_data : rd_data;

    stall_counter #(.STALL_MAX(STALL_MAX)) u_stall (
        .clk    (clk),
        .reset  (reset),
        .clear  ((state == IDLE && start) || (cap && opnd_ok)),
        .inc    (cap && !opnd_ok),
        .at_max (at_max)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rd_addr  <= '0;
            src_b_q  <= '0;
            two_op_q <= 1'b0;
            err      <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    src_b_q  <= src_b;
                    two_op_q <= two_op;
                    err      <= 1'b0;
                    rd_addr  <= src_a;
                    state    <= RD_A;
                end
                RD_A: state <= CAP_A;
                CAP_A: begin
                    if (opnd_ok) begin
                        op_a <= opnd;
                        if (two_op_q) begin
                            rd_addr <= src_b_q;
                            state   <= RD_B;
                        end else begin
                            op_b  <= '0;
                            state <= FIN;
                        end
                    end else if (at_max) begin
                        err   <= 1'b1;
                        op_a  <= '0;
                        op_b  <= '0;
                        state <= FIN;
                    end else begin
                        state <= RD_A;
                    end
                end
                RD_B: state <= CAP_B;
                CAP_B: begin
                    if (opnd_ok) begin
                        op_b  <= opnd;
                        state <= FIN;
                    end else if (at_max) begin
                        err   <= 1'b1;
                        op_a  <= '0;
                        op_b  <= '0;
                        state <= FIN;
                    end else begin
                        state <= RD_B;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == FIN);

endmodule

// File: tb/tb_operand_reader.sv
// Randomised check of operand_reader against a cycle-count model of the fetch rules and a register-bank model.
module tb_operand_reader;

    localparam int STALL = 15;
    localparam int NEVER = 1 << 30;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        two_op = 1'b0;
    logic [2:0]  src_a = '0;
    logic [2:0]  src_b = '0;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data = '0;
    logic        rd_valid = 1'b0;
    logic        wb_en = 1'b0;
    logic [2:0]  wb_addr = '0;
    logic [15:0] wb_data = '0;
    logic        busy, done, err;
    logic [15:0] op_a, op_b;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [15:0] mem [8];
    int          vcyc [8];

    operand_reader dut (
        .clk(clk), .reset(reset), .start(start), .two_op(two_op),
        .src_a(src_a), .src_b(src_b), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .busy(busy), .done(done), .err(err), .op_a(op_a), .op_b(op_b)
    );

    always #5 clk = ~clk;

    // Bank: registered read, a register turns valid at an absolute cycle number.
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rd_data  <= mem[rd_addr];
        rd_valid <= (cyc + 1 >= vcyc[rd_addr]);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // na/nb: not-valid samples before the register turns valid (>= STALL means never).
    task automatic run_op(input logic two, input logic [2:0] a, input logic [2:0] b,
                          input int na_in, input int nb_in,
                          input logic [15:0] da, input logic [15:0] db_in,
                          input bit poke, input bit byp);
        int na, nb, t0, lat, dcyc, cap_a;
        logic [15:0] db, ea, eb;
        logic ee;
        logic [2:0] eaddr;
        na = na_in;
        nb = (a == b) ? 0 : nb_in;
        db = (a == b) ? da : db_in;
        mem[a] = da;
        mem[b] = db;
        if (byp) begin
            wb_en = 1'b1; wb_addr = a; wb_data = 16'hFFFF;
        end
`ifdef BYPASS_EN
        if (byp) begin
            na = 0;
            da = 16'hFFFF;
        end
`endif
        // Reference outcome from the fetch rules.
        ee = 1'b0; ea = da; eb = two ? db : 16'h0; eaddr = two ? b : a;
        if (na >= STALL) begin
            ee = 1'b1; ea = 0; eb = 0; eaddr = a;
            lat = 2 + 2 * (STALL - 1) + 1;
        end else begin
            cap_a = 2 + 2 * na;
            if (!two) lat = cap_a + 1;
            else if (nb >= STALL) begin
                ee = 1'b1; ea = 0; eb = 0;
                lat = cap_a + 2 + 2 * (STALL - 1) + 1;
            end else lat = cap_a + 2 + 2 * nb + 1;
        end
        t0 = cyc;
        vcyc[a] = (byp || na >= STALL) ? NEVER : t0 + 2 + 2 * na;
        if (b != a && two && na < STALL)
            vcyc[b] = (nb >= STALL) ? NEVER : t0 + 4 + 2 * na + 2 * nb;
        start = 1'b1; two_op = two; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0;
        src_a = ~a;
        check("busy_after_start", busy, 1'b1);
        check("err_cleared", err, 1'b0);
        dcyc = -1;
        for (int i = 0; i < 60; i++) begin
            if (done) begin
                dcyc = cyc;
                break;
            end
            start = poke && (cyc == t0 + 2);
            @(negedge clk);
        end
        start = 1'b0;
        check("latency", dcyc - t0, lat);
        check("op_a", op_a, ea);
        check("op_b", op_b, eb);
        check("err", err, ee);
        check("rd_addr", rd_addr, eaddr);
        @(negedge clk);
        check("done_pulse", done, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("op_a_held", op_a, ea);
        wb_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            mem[i]  = 16'h0;
            vcyc[i] = 0;
        end
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_op_a", op_a, 16'h0);
        check("rst_op_b", op_b, 16'h0);
        check("rst_rd_addr", rd_addr, 3'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_op(1'b1, 3'd2, 3'd5, 0, 0, 16'hFFFB, 16'd300, 1'b0, 1'b0);
        run_op(1'b0, 3'd1, 3'd4, 0, 0, 16'h7FFF, 16'h1234, 1'b0, 1'b0);
        run_op(1'b0, 3'd3, 3'd0, 2, 0, 16'hA5A5, 16'h0, 1'b0, 1'b0);
        run_op(1'b1, 3'd6, 3'd7, STALL, 0, 16'h1111, 16'h2222, 1'b0, 1'b0);
        run_op(1'b1, 3'd6, 3'd7, 0, 1, 16'h3333, 16'h4444, 1'b0, 1'b0);
        run_op(1'b1, 3'd4, 3'd0, 1, STALL, 16'h5555, 16'h6666, 1'b0, 1'b0);
        run_op(1'b1, 3'd4, 3'd4, 1, 3, 16'h8001, 16'h0, 1'b0, 1'b0);
        run_op(1'b0, 3'd5, 3'd2, 0, 0, 16'h0042, 16'h0, 1'b1, 1'b0);
        run_op(1'b1, 3'd1, 3'd3, 0, 2, 16'h0077, 16'h0088, 1'b1, 1'b0);
        run_op(1'b0, 3'd2, 3'd0, STALL, 0, 16'h1357, 16'h0, 1'b0, 1'b1);

        // Asynchronous reset while in CAP_B aborts without done.
        begin
            int t0;
            mem[1] = 16'h0101; mem[2] = 16'h0202;
            t0 = cyc;
            vcyc[1] = t0 + 2; vcyc[2] = t0 + 4;
            start = 1'b1; two_op = 1'b1; src_a = 3'd1; src_b = 3'd2;
            @(negedge clk);
            start = 1'b0;
            while (cyc < t0 + 4) @(negedge clk);
            reset = 1'b0;
            #1;
            check("abort_busy", busy, 1'b0);
            check("abort_op_a", op_a, 16'h0);
            check("abort_rd_addr", rd_addr, 3'd0);
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                check("abort_no_done", done, 1'b0);
            end
            reset = 1'b1;
            @(negedge clk);
        end
        run_op(1'b1, 3'd2, 3'd1, 0, 0, 16'hBEEF, 16'hCAFE, 1'b0, 1'b0);

        for (int n = 0; n < 30; n++) begin
            int na, nb;
            na = ($urandom_range(0, 9) == 0) ? STALL : $urandom_range(0, 3);
            nb = ($urandom_range(0, 9) == 0) ? STALL : $urandom_range(0, 3);
            run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   na, nb, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
